// File: rtl/bram_fifo_ctrl.sv
// Stream-to-BRAM FIFO controller using a single-port block RAM as ring storage.
// A 2-entry output buffer hides the one-cycle BRAM read latency.
module bram_fifo_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clka_0,
    input  logic              rsta_n_0,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] addra_0,
    output logic [DATA_W-1:0] dina_0,
    output logic              wea_0,
    input  logic [DATA_W-1:0] douta_0,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic [DATA_W-1:0] obuf0_q, obuf0_d;
    logic [DATA_W-1:0] obuf1_q, obuf1_d;
    logic [1:0]        obuf_cnt_q, obuf_cnt_d;

    logic [1:0] occ;
    logic       full_w;
    logic       rd_elig;
    logic       rd_pri;
    logic       wr;
    logic       rd;
    logic       push;
    logic       pop;

    // Arbitration between the write stream and BRAM reads
    always_comb begin
        occ     = obuf_cnt_q + {1'b0, rd_inflight_q};
        full_w  = (count_q == DEPTH_C);
        rd_elig = (count_q != '0) && (occ < 2'd2);
        rd_pri  = rd_elig && (obuf_cnt_q == 2'd0);
        s_ready = rsta_n_0 && !full_w && !rd_pri;
        wr      = s_valid && s_ready;
        rd      = rsta_n_0 && rd_elig && !wr;
        push    = rd_inflight_q;
        pop     = m_valid && m_ready;
    end

    assign wea_0   = wr;
    assign addra_0 = wr ? wr_ptr_q : rd_ptr_q;
    assign dina_0  = s_data;
    assign m_valid = (obuf_cnt_q != 2'd0);
    assign m_data  = obuf0_q;
    assign count   = count_q;
    assign full    = rsta_n_0 && full_w;
    assign empty   = (count_q == '0) && (obuf_cnt_q == 2'd0) && !rd_inflight_q;

    // Next-state for pointers, occupancy and the output buffer
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        rd_inflight_d = rd;
        obuf0_d       = obuf0_q;
        obuf1_d       = obuf1_q;
        obuf_cnt_d    = obuf_cnt_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
        end else if (rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
        end
        if (push && pop) begin
            if (obuf_cnt_q == 2'd1) begin
                obuf0_d = douta_0;
            end else begin
                obuf0_d = obuf1_q;
                obuf1_d = douta_0;
            end
        end else if (pop) begin
            obuf0_d    = obuf1_q;
            obuf_cnt_d = obuf_cnt_q - 2'd1;
        end else if (push) begin
            if (obuf_cnt_q == 2'd0) begin
                obuf0_d = douta_0;
            end else begin
                obuf1_d = douta_0;
            end
            obuf_cnt_d = obuf_cnt_q + 2'd1;
        end
    end

    // State registers; reset discards stored words and any read in flight
    always_ff @(posedge clka_0 or negedge rsta_n_0) begin
        if (!rsta_n_0) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rd_inflight_q <= 1'b0;
            obuf0_q       <= '0;
            obuf1_q       <= '0;
            obuf_cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rd_inflight_q <= rd_inflight_d;
            obuf0_q       <= obuf0_d;
            obuf1_q       <= obuf1_d;
            obuf_cnt_q    <= obuf_cnt_d;
        end
    end

endmodule
